ula_multibyte_sequencer: RTL and testbench

- Sequences one shared 8-bit ALU instance byte by byte to execute NBYTES-wide operations: add, subtract, AND, OR, NOT.
- Chains carry/borrow between bytes in a registered flag, assembles the wide result and reports completion with a DONE pulse.
- Sits between a requester (START/READY handshake) and the 8-bit ALU. The ALU is instantiated beside this block and connected through the ALU_* ports.

---
 rtl/ula_multibyte_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_ula_multibyte_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_multibyte_sequencer.sv
// ula_multibyte_sequencer
// Runs an NBYTES-wide add/sub/and/or/not on a shared 8-bit ALU, one byte per
// cycle. The carry/borrow is chained between bytes in a register, the wide
// result is assembled in place, and completion is signalled by a DONE pulse.
// The ALU is outside this block and is reached through the ALU_* ports.

module ula_multibyte_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  READY,
  input  logic [3:0]            OP,
  input  logic [8*NBYTES-1:0]   OPA,
  input  logic [8*NBYTES-1:0]   OPB,
  input  logic                  CIN_IN,
  output logic [7:0]            ALU_A,
  output logic [7:0]            ALU_B,
  output logic [3:0]            ALU_X,
  output logic                  ALU_CIN,
  input  logic [7:0]            ALU_S,
  input  logic                  ALU_COUT,
  output logic [8*NBYTES-1:0]   RESULT,
  output logic                  COUT,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   idx_r;
  logic [3:0]      op_r;
  logic [W-1:0]    opa_r;
  logic [W-1:0]    opb_r;
  logic            carry_r;
  logic [W-1:0]    result_r;
  logic            cout_r;
  logic            done_r;
  logic            err_r;
  logic            ready_r;
  logic            last_s;
  logic [7:0]      alu_a_s;
  logic [7:0]      alu_b_s;
  logic [3:0]      alu_x_s;
  logic            alu_cin_s;

  // One of the five supported opcodes.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

  // Opcodes whose carry/borrow is chained between bytes.
  function automatic logic op_arith(input logic [3:0] op);
    op_arith = (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Byte i of a wide operand.
  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input logic [IW-1:0] i);
    logic [W-1:0] sh;
    sh      = v >> {i, 3'b000};
    byte_of = sh[7:0];
  endfunction

  assign last_s = (idx_r == LAST_IDX);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: legal ops run, illegal ops go straight to FIN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          if (op_legal(OP)) begin
            state_nxt_s = S_RUN;
          end else begin
            state_nxt_s = S_FIN;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_nxt_s = S_FIN;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_FIN:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand capture, byte index, carry chain, result assembly and flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_r    <= '0;
      op_r     <= 4'b0000;
      opa_r    <= '0;
      opb_r    <= '0;
      carry_r  <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (START) begin
            op_r    <= OP;
            opa_r   <= OPA;
            opb_r   <= OPB;
            idx_r   <= '0;
            err_r   <= ~op_legal(OP);
            cout_r  <= 1'b0;
            carry_r <= op_arith(OP) ? CIN_IN : 1'b0;
          end
        end
        S_RUN: begin
          for (int b = 0; b < NBYTES; b++) begin
            if (idx_r == IW'(b)) begin
              result_r[8*b +: 8] <= ALU_S;
            end
          end
          carry_r <= op_arith(op_r) ? ALU_COUT : 1'b0;
          if (last_s) begin
            // The ALU reports COUT=1 on NOT; only add/sub carry is meaningful.
            cout_r <= op_arith(op_r) ? ALU_COUT : 1'b0;
            idx_r  <= '0;
          end else begin
            idx_r  <= idx_r + IW'(1);
          end
        end
        S_FIN: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // Handshake outputs registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      done_r  <= (state_nxt_s == S_FIN);
      ready_r <= (state_nxt_s == S_IDLE);
    end
  end

  // ALU drive: only registered state reaches the ALU; idle/finish drive zeros.
  always_comb begin
    alu_a_s   = 8'h00;
    alu_b_s   = 8'h00;
    alu_x_s   = 4'b0000;
    alu_cin_s = 1'b0;
    if (state_r == S_RUN) begin
      alu_a_s   = byte_of(opa_r, idx_r);
      alu_b_s   = byte_of(opb_r, idx_r);
      alu_x_s   = op_r;
      alu_cin_s = carry_r;
    end else begin
      alu_a_s   = 8'h00;
      alu_b_s   = 8'h00;
      alu_x_s   = 4'b0000;
      alu_cin_s = 1'b0;
    end
  end

  assign ALU_A   = alu_a_s;
  assign ALU_B   = alu_b_s;
  assign ALU_X   = alu_x_s;
  assign ALU_CIN = alu_cin_s;
  assign RESULT  = result_r;
  assign COUT    = cout_r;
  assign DONE    = done_r;
  assign ERR     = err_r;
  assign READY   = ready_r;

endmodule

// File: tb/tb_ula_multibyte_sequencer.sv
// Testbench for ula_multibyte_sequencer: a behavioural 8-bit ALU sits beside
// the DUT; fixed vectors and random operations are checked against whole-word
// arithmetic, plus hand-written reset-abort and held-START sequences.

module tb_ula_multibyte_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          READY;
  logic [3:0]    OP;
  logic [W-1:0]  OPA;
  logic [W-1:0]  OPB;
  logic          CIN_IN;
  logic [7:0]    ALU_A;
  logic [7:0]    ALU_B;
  logic [3:0]    ALU_X;
  logic          ALU_CIN;
  logic [7:0]    ALU_S;
  logic          ALU_COUT;
  logic [W-1:0]  RESULT;
  logic          COUT;
  logic          DONE;
  logic          ERR;

  logic [8:0]    alu_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] model_prev;

  ula_multibyte_sequencer #(.NBYTES(NB)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .OP(OP),
    .OPA(OPA), .OPB(OPB), .CIN_IN(CIN_IN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_X(ALU_X), .ALU_CIN(ALU_CIN),
    .ALU_S(ALU_S), .ALU_COUT(ALU_COUT),
    .RESULT(RESULT), .COUT(COUT), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Behavioural 8-bit ALU (NOT reports COUT=1, which the sequencer must drop).
  always_comb begin
    alu_t    = 9'd0;
    ALU_S    = 8'h00;
    ALU_COUT = 1'b0;
    case (ALU_X)
      4'b0000: begin
        alu_t    = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_CIN};
        ALU_S    = alu_t[7:0];
        ALU_COUT = alu_t[8];
      end
      4'b0100: begin
        alu_t    = {1'b0, ALU_A} - {1'b0, ALU_B} - {8'd0, ALU_CIN};
        ALU_S    = alu_t[7:0];
        ALU_COUT = alu_t[8];
      end
      4'b0010: ALU_S = ALU_A & ALU_B;
      4'b0110: ALU_S = ALU_A | ALU_B;
      4'b0001: begin
        ALU_S    = ~ALU_A;
        ALU_COUT = 1'b1;
      end
      default: begin
        ALU_S    = 8'h00;
        ALU_COUT = 1'b0;
      end
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-word reference: result, carry/borrow and error for one operation.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic [W-1:0] res, output logic co,
                       output logic er);
    longint unsigned sa, sb, sc;
    sa = longint'(a); sb = longint'(b); sc = longint'(cin);
    co = 1'b0; er = 1'b0; res = model_prev;
    case (op)
      4'b0000: begin res = W'(sa + sb + sc); co = ((sa + sb + sc) >> W) != 0; end
      4'b0100: begin res = W'(sa - sb - sc); co = (sa < sb + sc); end
      4'b0010: res = a & b;
      4'b0110: res = a | b;
      4'b0001: res = ~a;
      default: begin res = model_prev; er = 1'b1; end
    endcase
    model_prev = res;
  endtask

  // Issue one operation and check result, flags, latency and handshake.
  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic [W-1:0] eres,
                       input logic eco, input logic eer);
    int   w, lat, elat;
    bit   rdy_low_ok, cin_ok, is_logic;
    logic er1;
    w = 0;
    while (!READY && w < 20) begin
      @(posedge CLK); #1; w++;
    end
    chk({name, "_ready_wait"}, 64'(READY), 64'd1);
    OP = op; OPA = a; OPB = b; CIN_IN = cin; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    OP = 4'($urandom); OPA = W'($urandom); OPB = W'($urandom); CIN_IN = 1'($urandom);
    is_logic = (op == 4'b0010) || (op == 4'b0110) || (op == 4'b0001);
    er1 = ERR;
    lat = 1; rdy_low_ok = 1'b1; cin_ok = 1'b1;
    while (!DONE && lat < 40) begin
      if (READY) rdy_low_ok = 1'b0;
      if (ALU_CIN !== 1'b0) cin_ok = 1'b0;
      @(posedge CLK); #1; lat++;
    end
    if (READY) rdy_low_ok = 1'b0;
    elat = eer ? 1 : NB + 1;
    chk({name, "_latency"}, 64'(lat), 64'(elat));
    chk({name, "_result"}, 64'(RESULT), 64'(eres));
    chk({name, "_cout"}, 64'(COUT), 64'(eco));
    chk({name, "_err"}, 64'(ERR), 64'(eer));
    chk({name, "_err_on_accept"}, 64'(er1), 64'(eer));
    chk({name, "_ready_low"}, 64'(rdy_low_ok), 64'd1);
    if (is_logic) chk({name, "_alu_cin_zero"}, 64'(cin_ok), 64'd1);
    @(posedge CLK); #1;
    chk({name, "_done_one_cycle"}, 64'(DONE), 64'd0);
    chk({name, "_ready_after"}, 64'(READY), 64'd1);
  endtask

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] eres;
    logic         eco;
    logic         eer;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] mres, ra, rb;
    logic         mco, mer, rc;
    logic [3:0]   rop;
    int           dones;

    vecs[0] = '{"add_ripple", 4'b0000, 32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0};
    vecs[1] = '{"add_wrap",   4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{"add_cin",    4'b0000, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0};
    vecs[3] = '{"sub_borrow", 4'b0100, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[4] = '{"sub_plain",  4'b0100, 32'h12345678, 32'h02345678, 1'b0, 32'h10000000, 1'b0, 1'b0};
    vecs[5] = '{"and",        4'b0010, 32'hF0F0A5A5, 32'h0FF0FF00, 1'b1, 32'h00F0A500, 1'b0, 1'b0};
    vecs[6] = '{"or",         4'b0110, 32'hF0F0A5A5, 32'h0FF0FF00, 1'b1, 32'hFFF0FFA5, 1'b0, 1'b0};
    vecs[7] = '{"not",        4'b0001, 32'hF0F0A5A5, 32'h0FF0FF00, 1'b1, 32'h0F0F5A5A, 1'b0, 1'b0};
    vecs[8] = '{"illegal",    4'b1000, 32'h11111111, 32'h22222222, 1'b1, 32'h0F0F5A5A, 1'b0, 1'b1};
    vecs[9] = '{"after_err",  4'b0000, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0};

    RST = 1'b1; START = 1'b0; OP = 4'b0000; OPA = '0; OPB = '0; CIN_IN = 1'b0;
    model_prev = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("reset_ready", 64'(READY), 64'd1);
    chk("reset_done", 64'(DONE), 64'd0);
    chk("reset_result", 64'(RESULT), 64'd0);
    chk("reset_cout", 64'(COUT), 64'd0);
    chk("reset_err", 64'(ERR), 64'd0);
    chk("idle_alu_x", 64'(ALU_X), 64'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].eres, vecs[i].eco, vecs[i].eer);
    end
    model_prev = vecs[9].eres;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: rop = 4'b0000;
        1: rop = 4'b0100;
        2: rop = 4'b0010;
        3: rop = 4'b0110;
        4: rop = 4'b0001;
        default: rop = 4'($urandom);
      endcase
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i % 7 == 0) rb = ~ra;
      model(rop, ra, rb, rc, mres, mco, mer);
      do_op($sformatf("rand%0d", i), rop, ra, rb, rc, mres, mco, mer);
    end

    // Reset during the RUN cycle for byte 2 aborts the operation.
    OP = 4'b0000; OPA = 32'h01010101; OPB = 32'h01010101; CIN_IN = 1'b0; START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("abort_partial_bytes", 64'(RESULT[15:0]), 64'h0202);
    chk("abort_not_ready", 64'(READY), 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    chk("abort_result", 64'(RESULT), 64'd0);
    chk("abort_cout", 64'(COUT), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    chk("abort_ready", 64'(READY), 64'd1);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (DONE) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    model_prev = '0;

    // START held high throughout RUN must not start a second operation.
    model(4'b0100, 32'h80000000, 32'h00000001, 1'b1, mres, mco, mer);
    OP = 4'b0100; OPA = 32'h80000000; OPB = 32'h00000001; CIN_IN = 1'b1; START = 1'b1;
    dones = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        dones++;
        chk("held_start_result", 64'(RESULT), 64'(mres));
        chk("held_start_cout", 64'(COUT), 64'(mco));
      end
      if (c >= NB + 1) START = 1'b0;
    end
    chk("held_start_one_done", 64'(dones), 64'd1);
    chk("held_start_idle", 64'(READY), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
